// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button debouncer and its users.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`include "button_defs.vh"

package button_debouncer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT   = `BTN_DEBOUNCE_CYCLES_DEFAULT;
    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = `BTN_LONG_PRESS_CYCLES_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE         = `BTN_ST_IDLE,
        ST_PRESS_WAIT   = `BTN_ST_PRESS_WAIT,
        ST_PRESSED      = `BTN_ST_PRESSED,
        ST_RELEASE_WAIT = `BTN_ST_RELEASE_WAIT
    } state_t;

    // Width of the debounce/hold counters: large enough to hold
    // LONG_PRESS_CYCLES without wrapping.
    function automatic int unsigned cnt_width(input int unsigned long_cycles);
        return $clog2(long_cycles + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-low reset, clears both flops
//   d   - asynchronous input bit
//   q   - synchronized output (second flop)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_defs.vh
// Shared constants for the button debouncer: state encodings and default timing.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
`ifndef BUTTON_DEFS_VH
`define BUTTON_DEFS_VH

// Default timing, in core clock cycles
`define BTN_DEBOUNCE_CYCLES_DEFAULT   4
`define BTN_LONG_PRESS_CYCLES_DEFAULT 20

// FSM state encodings
`define BTN_ST_IDLE         2'd0
`define BTN_ST_PRESS_WAIT   2'd1
`define BTN_ST_PRESSED      2'd2
`define BTN_ST_RELEASE_WAIT 2'd3

`endif

// File: rtl/button_debouncer.sv
// Push-button debouncer with press, release and long-press strobes.
// Latency: press/release strobe high in the cycle after edge DEBOUNCE_CYCLES+2 of a stable level.
// Backpressure: none; strobes are one-cycle, fire-and-forget.
//
// Ports:
//   clk              - rising-edge clock
//   rst              - synchronous active-low reset
//   btn_in           - raw asynchronous button, 1 = pressed
//   btn_level        - debounced level (registered)
//   press_pulse      - one-cycle strobe on accepted press (registered)
//   release_pulse    - one-cycle strobe on accepted release (registered)
//   long_press_pulse - one-cycle strobe LONG_PRESS_CYCLES after press_pulse (registered)
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int unsigned     CW        = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(LONG_PRESS_CYCLES - 1);

    logic          btn_sync;

    state_t        state_q;
    logic [CW-1:0] db_cnt_q;
    logic [CW-1:0] hold_cnt_q;
    logic          long_done_q;
    logic          btn_level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    logic          release_accept;
    logic          hold_active;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    // Release is accepted on this edge; the long-press strobe must yield to it.
    assign release_accept = (state_q == ST_RELEASE_WAIT) && !btn_sync && (db_cnt_q == DB_LAST);

    // Hold time keeps running through release-side bounces, so a bounce
    // back into PRESSED does not restart the long-press timer.
    assign hold_active = (state_q == ST_PRESSED) ||
                         ((state_q == ST_RELEASE_WAIT) && !release_accept);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (btn_sync) begin
                        state_q  <= ST_PRESS_WAIT;
                        db_cnt_q <= '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state_q <= ST_IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= ST_PRESSED;
                        btn_level_q <= 1'b1;
                        press_q     <= 1'b1;
                        hold_cnt_q  <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + CNT_ONE;
                    end
                end

                ST_PRESSED: begin
                    if (!btn_sync) begin
                        state_q  <= ST_RELEASE_WAIT;
                        db_cnt_q <= '0;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state_q <= ST_PRESSED;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= ST_IDLE;
                        btn_level_q <= 1'b0;
                        release_q   <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Hold counter saturates at HOLD_LAST; the edge after it first
            // sits there fires the long-press strobe, once per press.
            if (hold_active) begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (!long_done_q) begin
                        long_q      <= 1'b1;
                        long_done_q <= 1'b1;
                    end
                end else begin
                    hold_cnt_q <= hold_cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign btn_level        = btn_level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random button activity.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_DEFAULT;
    localparam int L = LONG_PRESS_CYCLES_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    button_debouncer #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_in           (btn_in),
        .btn_level        (btn_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        int cyc;
        int kind;   // 0 press, 1 release, 2 long press
    } ev_t;

    ev_t exp_q[$];
    int  tests  = 0;
    int  fails  = 0;
    int  edge_n = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "press_pulse";
            1:       return "release_pulse";
            default: return "long_press_pulse";
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Button value seen by the debouncer at an edge is the value sampled two
    // edges earlier (0 while in reset). A level change is accepted once that
    // seen value has held the new level for D+1 consecutive edges; a long
    // press is due exactly L edges after the accepted press, unless the
    // release is accepted on or before that edge.
    bit m_d1, m_d2, m_cur;
    int m_ones, m_zeros, m_press_edge;
    bit level_exp;

    initial begin
        m_d1 = 0; m_d2 = 0; m_ones = 0; m_zeros = 0; m_press_edge = -1; level_exp = 0;
    end

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst) begin
            m_d1 = 0; m_d2 = 0; m_ones = 0; m_zeros = 0;
            m_press_edge = -1; level_exp = 0;
        end else begin
            m_cur = m_d2;
            m_d2  = m_d1;
            m_d1  = btn_in;
            if (m_cur) begin m_ones = m_ones + 1; m_zeros = 0; end
            else       begin m_zeros = m_zeros + 1; m_ones = 0; end

            if (!level_exp && m_ones == D + 1) begin
                level_exp    = 1;
                m_press_edge = edge_n;
                exp_q.push_back('{cyc: edge_n, kind: 0});
            end else if (level_exp && m_zeros == D + 1) begin
                level_exp    = 0;
                m_press_edge = -1;
                exp_q.push_back('{cyc: edge_n, kind: 1});
            end else if (level_exp && m_press_edge >= 0 && edge_n == m_press_edge + L) begin
                exp_q.push_back('{cyc: edge_n, kind: 2});
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic chk_strobe(input logic s, input int k);
        if (s !== 1'b0) begin
            tests = tests + 1;
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n && exp_q[0].kind == k) begin
                void'(exp_q.pop_front());
            end else begin
                fails = fails + 1;
                $display("FAIL strobe %s at edge %0d: got %b, required 0 (no event due)",
                         kname(k), edge_n, s);
            end
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missing %s: required high after edge %0d, got 0",
                     kname(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        chk_strobe(press_pulse, 0);
        chk_strobe(release_pulse, 1);
        chk_strobe(long_press_pulse, 2);
        tests = tests + 1;
        if (btn_level !== level_exp) begin
            fails = fails + 1;
            $display("FAIL btn_level at edge %0d: got %b, required %b", edge_n, btn_level, level_exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int r;
        rst    = 1'b0;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // clean press held long enough for a long press, then release
        drive(1'b1, 40);
        drive(1'b0, 15);
        // press-side bounce: never stable long enough
        drive(1'b1, 3);
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 12);
        // short press with release-side bounce
        drive(1'b1, 12);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 15);
        // release accepted on the very edge the long press would fire
        drive(1'b1, L);
        drive(1'b0, 15);
        // release accepted one edge after the long press
        drive(1'b1, L + 1);
        drive(1'b0, 15);
        // reset for one edge while pressed and held
        drive(1'b1, 12);
        rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        drive(1'b1, 15);
        drive(1'b0, 15);

        // random activity with occasional resets
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                rst = 1'b0;
                drive(btn_in, int'($urandom_range(1, 2)));
                rst = 1'b1;
            end else if (r < 5) begin
                drive(~btn_in, int'($urandom_range(D + 2, L + 8)));
            end else begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(1, D + 2)));
            end
        end

        rst = 1'b1;
        drive(1'b0, 30);

        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL pending events at end: got %0d outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a level change; legal range >= 2.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 20: cycles after an accepted press before a long press is flagged; legal range > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk, input, 1: single master clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset; reset when rst = 0 at a rising clk edge.
REQ-005 SHALL have port btn_in, input, 1: raw asynchronous push-button; 1 = pressed.
REQ-006 SHALL have port btn_level, output, 1: debounced button level; registered.
REQ-007 SHALL have port press_pulse, output, 1: one-cycle strobe on accepted press; registered.
REQ-008 SHALL have port release_pulse, output, 1: one-cycle strobe on accepted release; registered.
REQ-009 SHALL have port long_press_pulse, output, 1: one-cycle strobe when a press has been held LONG_PRESS_CYCLES; registered.

Function
REQ-010 SHALL pass btn_in through a two-flop synchronizer (s1, s2); the FSM uses only s2.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: s2 = 1 -> PRESS_WAIT with debounce counter = 0; otherwise stay in IDLE.
REQ-013 PRESS_WAIT: s2 = 0 -> IDLE (bounce, no output); s2 = 1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED, btn_level <= 1, press_pulse <= 1, hold counter <= 0; otherwise counter increments.
REQ-014 PRESSED: s2 = 0 -> RELEASE_WAIT with debounce counter = 0; otherwise stay in PRESSED.
REQ-015 RELEASE_WAIT: s2 = 1 -> PRESSED (bounce, no output); s2 = 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE, btn_level <= 0, release_pulse <= 1; otherwise counter increments.
REQ-016 Hold counter SHALL increment every cycle in PRESSED and RELEASE_WAIT and saturate at LONG_PRESS_CYCLES-1. It SHALL NOT be cleared by a release-side bounce.
REQ-017 long_press_pulse SHALL assert exactly once per accepted press: on the edge after the hold counter first equals LONG_PRESS_CYCLES-1, i.e. exactly LONG_PRESS_CYCLES cycles after press_pulse. It SHALL NOT assert if release is accepted earlier.
REQ-018 If release is accepted on the same edge that long_press_pulse would fire, release_pulse SHALL assert and long_press_pulse SHALL NOT.
REQ-019 Latency: with edge 0 = first edge sampling a stable new btn_in level, press_pulse or release_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-020 All strobes SHALL be high for exactly one cycle; press_pulse and release_pulse SHALL never both be high.
REQ-021 Counters SHALL be sized $clog2(LONG_PRESS_CYCLES+1) bits, unsigned, with no wrap-around.

Reset
REQ-022 When rst = 0 at an edge: state IDLE, s1 = s2 = 0, counters = 0, long-press flag cleared, and btn_level, press_pulse, release_pulse, long_press_pulse = 0, regardless of current state.
REQ-023 Reset mid-press SHALL emit no release_pulse. A button still held after rst returns to 1 SHALL be re-detected with the full REQ-019 latency.

Structure
REQ-024 State encodings and default parameter constants SHALL live in shared header button_defs.vh, included by RTL and bench.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (ports clk, rst, d, q), reusable by other blocks.

Verification (DEBOUNCE_CYCLES = 4, LONG_PRESS_CYCLES = 20, clk period 10 ns, rst = 0 for first 2 edges)
REQ-026 Clean press: btn_in 0 -> 1 and held, first sampled at edge E. Required: press_pulse high in the cycle after edge E+6; btn_level = 1 from then on.
REQ-027 Bounce rejection: btn_in high 3 cycles, low 1, high 2, then low. Required: no strobes, btn_level stays 0.
REQ-028 Long press: hold btn_in for 40 cycles. Required: long_press_pulse exactly 20 cycles after press_pulse, exactly once. Release then yields release_pulse 6 edges after the release is first sampled, with btn_level -> 0.
REQ-029 Short press with release bounce: press 12 cycles, low 2, high 1, low. Required: one press_pulse, one release_pulse, no long_press_pulse.
REQ-030 Reset mid-press: rst = 0 for one edge while in PRESSED with btn_in held. Required: all outputs 0 the next cycle, no release_pulse. After rst returns to 1, press_pulse is re-issued 6 edges later.
